// File: rtl/vec_store_unit.sv
// Vector store unit: latches a vector register group plus base/stride on a store
// instruction and streams one element per accepted memory beat to the write port.
module vec_store_unit #(
  parameter int XLEN  = 32,
  parameter int VLEN  = 512,
  parameter int VLMAX = 16,
  parameter int SEW   = 32,
  parameter int LMUL  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [9:0]           vlmax,
  input  logic                 stride_sel,
  input  logic                 st_inst,
  input  logic                 mew,
  input  logic [2:0]           width,
  input  logic [VLEN*LMUL-1:0] vs3_data,
  output logic [XLEN-1:0]      lsu2mem_addr,
  output logic [SEW-1:0]       lsu2mem_data,
  output logic [SEW/8-1:0]     lsu2mem_wstrb,
  output logic                 lsu2mem_wen,
  input  logic                 mem2lsu_ready,
  output logic                 is_stored,
  output logic                 st_illegal
);

  localparam int NSLOT = (VLEN * LMUL) / SEW;
  localparam int IDXW  = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int NBYTE = SEW / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           r_state;
  logic [XLEN-1:0]      r_addr;
  logic [XLEN-1:0]      r_stride;
  logic [2:0]           r_eb;
  logic [9:0]           r_cnt;
  logic [9:0]           r_idx;
  logic [VLEN*LMUL-1:0] r_vdata;
  logic                 r_illegal;

  logic [2:0]      w_eb;
  logic            w_legal;
  logic [9:0]      w_n;
  logic [XLEN-1:0] w_stride;
  logic            w_wen;
  logic [SEW-1:0]  w_slots [NSLOT];
  logic [SEW-1:0]  w_elem;
  logic [SEW-1:0]  w_data;
  logic [NBYTE-1:0] w_strb;

  always_comb begin
    w_eb    = 3'd0;
    w_legal = 1'b0;
    case (width)
      3'b000:  begin w_eb = 3'd1; w_legal = ~mew; end
      3'b101:  begin w_eb = 3'd2; w_legal = ~mew; end
      3'b110:  begin w_eb = 3'd4; w_legal = ~mew; end
      default: begin w_eb = 3'd0; w_legal = 1'b0; end
    endcase
  end

  assign w_n      = (vlmax > 10'(VLMAX)) ? 10'(VLMAX) : vlmax;
  assign w_stride = stride_sel ? XLEN'(w_eb) : rs2_data;
  assign w_wen    = (r_state == S_STORE);

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      assign w_slots[gi] = r_vdata[gi*SEW +: SEW];
    end
  endgenerate

  assign w_elem = w_slots[r_idx[IDXW-1:0]];

  // Only the low eb bytes of the element go out; the rest are forced to zero.
  generate
    for (gi = 0; gi < NBYTE; gi++) begin : g_byte
      assign w_strb[gi]         = (32'(r_eb) > 32'(gi));
      assign w_data[gi*8 +: 8]  = w_strb[gi] ? w_elem[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Address advances by the stride per accepted beat, which equals base + idx*stride mod 2^XLEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_stride  <= '0;
      r_eb      <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_vdata   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (st_inst) begin
            if (w_legal) begin
              r_addr   <= rs1_data;
              r_stride <= w_stride;
              r_eb     <= w_eb;
              r_cnt    <= w_n;
              r_idx    <= '0;
              r_vdata  <= vs3_data;
              r_state  <= (w_n != 10'd0) ? S_STORE : S_DONE;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_STORE: begin
          if (mem2lsu_ready) begin
            r_idx  <= r_idx + 10'd1;
            r_addr <= r_addr + r_stride;
            if (r_idx == r_cnt - 10'd1) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lsu2mem_wen   = w_wen;
  assign lsu2mem_addr  = w_wen ? r_addr : '0;
  assign lsu2mem_data  = w_wen ? w_data : '0;
  assign lsu2mem_wstrb = w_wen ? w_strb : '0;
  assign is_stored     = (r_state == S_DONE);
  assign st_illegal    = r_illegal;

endmodule

// File: doc/vec_store_unit.md
Name: vec_store_unit

Overview:
Vector store unit: the write-direction counterpart of vec_lsu.
On a store instruction it captures a vector register group (vs3) and a base address and stride from the scalar core. It then writes one element per accepted memory beat to main memory using unit or constant stride. It sits between the vector register file / controller and the main-memory write port, and signals completion with a single-cycle is_stored pulse.

Parameters:
XLEN, 32, scalar address/data width
VLEN, 512, bits per vector register
VLMAX, 16, max elements per register group (VLEN*LMUL/SEW)
SEW, 32, element slot width in vs3_data (bits)
LMUL, 1, register grouping factor

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
rs1_data  input  XLEN  base byte address
rs2_data  input  XLEN  constant byte stride (used when stride_sel=0)
vlmax  input  10  element count for this instruction
stride_sel  input  1  1 = unit stride, 0 = constant stride rs2_data
st_inst  input  1  store start, sampled only in IDLE
mew  input  1  must be 0; 1 = illegal
width  input  3  memory element width: 000=8b, 101=16b, 110=32b, other=illegal
vs3_data  input  VLEN*LMUL  source vector data; element i at [i*SEW +: SEW]
lsu2mem_addr  output  XLEN  write byte address
lsu2mem_data  output  SEW  write data, element zero-extended
lsu2mem_wstrb  output  SEW/8  byte strobes, low eb bits set
lsu2mem_wen  output  1  write request valid
mem2lsu_ready  input  1  memory accepts write this cycle
is_stored  output  1  one-cycle completion pulse
st_illegal  output  1  one-cycle pulse on illegal mew/width

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs 0. Element counter and latched registers cleared. An in-flight beat is dropped; no further wen.
- FSM states: IDLE, STORE, DONE.
- IDLE, st_inst=1, mew=0, width legal, on the clock edge:
  - latch base=rs1_data and vs3_data.
  - element bytes eb = 1/2/4 for width 000/101/110.
  - stride = eb when stride_sel=1, else rs2_data.
  - count n = min(vlmax, VLMAX).
  - idx = 0.
  - go to STORE if n>0, else DONE.
- IDLE, st_inst=1 with mew=1 or illegal width: st_illegal=1 next cycle, stay IDLE, no write.
- STORE outputs (registered/stable while waiting):
  - lsu2mem_wen=1.
  - lsu2mem_addr = base + idx*stride, mod 2^XLEN, wraps silently.
  - lsu2mem_data = low eb bytes of element idx, upper bytes 0.
  - lsu2mem_wstrb = (1<<eb)-1.
- Handshake: a beat completes on an edge with wen=1 and mem2lsu_ready=1.
  - On completion: idx increments.
  - If idx was n-1, go to DONE and drop wen on that edge.
  - While ready=0, addr/data/wstrb/wen hold unchanged (no timeouts).
- DONE: is_stored=1 for exactly one cycle, then IDLE. First new st_inst is accepted in the IDLE cycle after DONE.
- st_inst during STORE/DONE: ignored, not queued. Changes on vs3_data, rs1, rs2 after latch: no effect.
- Latency with ready tied high and n elements:
  - first wen in cycle after st_inst edge;
  - n beats back-to-back;
  - is_stored in cycle n+1 after start.
- idx*stride uses the full XLEN product, truncated to XLEN.

Test Plan:
- Unit stride: rs1=0x200, width=110, vlmax=8, ready=1 → addrs 0x200,0x204,…,0x21C; data = vs3 elements 0..7; wstrb=4'hF; is_stored 9 cycles after start.
- Constant stride: rs1=0x400, rs2=0x10, width=110, vlmax=16 → addrs 0x400…0x4F0 step 0x10; 16 beats; single is_stored pulse.
- Byte width with backpressure: width=000, stride_sel=1, rs1=0x300, vlmax=4; ready low 2 cycles per beat → addrs 0x300–0x303; wstrb=4'h1; data=element&0xFF; outputs stable while stalled.
- Boundaries:
  - vlmax=0 → no wen, is_stored pulse next cycle.
  - vlmax=20 → exactly 16 beats.
  - rs1=0xFFFFFFFC, stride 4 → second addr 0x00000000.
- Illegal cases:
  - mew=1 → st_illegal pulse, no wen, no is_stored.
  - width=111 → same.
  - st_inst pulsed mid-STORE → ignored, original count completes.
- Reset mid-STORE (after 3 of 8 beats) → wen=0 and all outputs 0 immediately (async). A fresh store then runs correctly from idx 0.
